// File: rtl/dpram_xpose_ctrl_if.sv
// Bus bundle for the ping-pong transpose controller: upstream sample stream,
// downstream transposed stream, both RAM ports and the block-done pulse.
// master = the controller side, slave = the surrounding environment.
interface dpram_xpose_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 8
);
   localparam int ADDR_WIDTH = 2 * $clog2(N) + 1;

   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] ram_addr_a;
   logic [DATA_WIDTH-1:0] ram_data_a;
   logic                  ram_we_a;
   logic [ADDR_WIDTH-1:0] ram_addr_b;
   logic [DATA_WIDTH-1:0] ram_data_b;
   logic                  ram_we_b;
   logic [DATA_WIDTH-1:0] ram_q_b;
   logic                  block_done;

   modport master (
      input  in_data, in_valid, out_ready, ram_q_b,
      output in_ready, out_data, out_valid,
      output ram_addr_a, ram_data_a, ram_we_a,
      output ram_addr_b, ram_data_b, ram_we_b,
      output block_done
   );

   modport slave (
      output in_data, in_valid, out_ready, ram_q_b,
      input  in_ready, out_data, out_valid,
      input  ram_addr_a, ram_data_a, ram_we_a,
      input  ram_addr_b, ram_data_b, ram_we_b,
      input  block_done
   );
endinterface

// File: rtl/dpram_xpose_ctrl.sv
// Ping-pong N x N transpose controller driving a 2*N*N dual-port RAM.
// Port A writes incoming row-major blocks into the write bank; port B reads
// the other (full) bank column-major into a 2-entry output FIFO.
// Optional feature macro XPOSE_BYPASS_EN adds input xpose_bypass, which
// selects row-major (untransposed) read-out, latched per block at its first read.
module dpram_xpose_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 8
) (
   input  logic clk,
   input  logic resetn,
`ifdef XPOSE_BYPASS_EN
   input  logic xpose_bypass,
`endif
   dpram_xpose_ctrl_if.master bus
);

   localparam int LOG_N      = $clog2(N);
   localparam int CNT_W      = 2 * LOG_N;
   localparam int ADDR_WIDTH = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N * N - 1);

   // bank / counter state
   logic                  wr_bank_r;
   logic                  rd_bank_r;
   logic [CNT_W-1:0]      wr_cnt_r;
   logic [CNT_W-1:0]      rd_cnt_r;
   logic [1:0]            bank_full_r;
   logic                  inflight_r;
   logic                  inflight_last_r;

   // 2-entry output FIFO; each entry carries an end-of-block tag
   logic [DATA_WIDTH-1:0] fifo_data_r [2];
   logic [1:0]            fifo_last_r;
   logic                  fifo_wr_ptr_r;
   logic                  fifo_rd_ptr_r;
   logic [1:0]            fifo_cnt_r;

   logic                  in_ready_s;
   logic                  in_fire_s;
   logic                  out_valid_s;
   logic                  out_fire_s;
   logic                  wr_last_s;
   logic                  rd_last_s;
   logic [2:0]            occ_sum_s;
   logic [2:0]            occ_limit_s;
   logic                  credit_ok_s;
   logic                  rd_issue_s;
   logic                  bypass_s;
   logic [ADDR_WIDTH-1:0] ram_addr_b_s;
   logic [1:0]            bank_full_nxt_s;

`ifdef XPOSE_BYPASS_EN
   logic                  bypass_r;

   // latch the read-order selection at the first read of each block
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bypass_r <= 1'b0;
      end else if (rd_issue_s && (rd_cnt_r == {CNT_W{1'b0}})) begin
         bypass_r <= xpose_bypass;
      end
   end

   // the first read of a block uses the live input, the rest the latched copy
   always_comb begin
      bypass_s = 1'b0;
      if (rd_cnt_r == {CNT_W{1'b0}}) begin
         bypass_s = xpose_bypass;
      end else begin
         bypass_s = bypass_r;
      end
   end
`else
   assign bypass_s = 1'b0;
`endif

   // handshake, credit and read-issue decisions
   always_comb begin
      in_ready_s  = ~bank_full_r[wr_bank_r];
      in_fire_s   = bus.in_valid && in_ready_s && resetn;
      out_valid_s = (fifo_cnt_r != 2'd0);
      out_fire_s  = out_valid_s && bus.out_ready;
      wr_last_s   = (wr_cnt_r == CNT_LAST);
      rd_last_s   = (rd_cnt_r == CNT_LAST);
      // buffered + in-flight, after this cycle's pop, must stay below 2
      occ_sum_s   = {1'b0, fifo_cnt_r} + {2'b00, inflight_r};
      occ_limit_s = 3'd2 + {2'b00, out_fire_s};
      credit_ok_s = (occ_sum_s < occ_limit_s);
      rd_issue_s  = bank_full_r[rd_bank_r] && credit_ok_s;
   end

   // port-B address: rd_cnt = {col, row}; transposed order swaps the halves
   always_comb begin
      ram_addr_b_s = {ADDR_WIDTH{1'b0}};
      if (bypass_s) begin
         ram_addr_b_s = {rd_bank_r, rd_cnt_r};
      end else begin
         ram_addr_b_s = {rd_bank_r, rd_cnt_r[LOG_N-1:0], rd_cnt_r[CNT_W-1:LOG_N]};
      end
   end

   // full-flag update; writer and reader never touch the same bank here
   always_comb begin
      bank_full_nxt_s = bank_full_r;
      if (in_fire_s && wr_last_s) begin
         bank_full_nxt_s[wr_bank_r] = 1'b1;
      end else begin
         bank_full_nxt_s[wr_bank_r] = bank_full_r[wr_bank_r];
      end
      if (rd_issue_s && rd_last_s) begin
         bank_full_nxt_s[rd_bank_r] = 1'b0;
      end else begin
         bank_full_nxt_s[rd_bank_r] = bank_full_nxt_s[rd_bank_r];
      end
   end

   // write/read counters, bank pointers and the in-flight read tracker
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_bank_r       <= 1'b0;
         rd_bank_r       <= 1'b0;
         wr_cnt_r        <= {CNT_W{1'b0}};
         rd_cnt_r        <= {CNT_W{1'b0}};
         bank_full_r     <= 2'b00;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
      end else begin
         bank_full_r     <= bank_full_nxt_s;
         inflight_r      <= rd_issue_s;
         inflight_last_r <= rd_issue_s && rd_last_s;
         if (in_fire_s) begin
            wr_cnt_r <= wr_cnt_r + CNT_W'(1);
            if (wr_last_s) begin
               wr_bank_r <= ~wr_bank_r;
            end
         end
         if (rd_issue_s) begin
            rd_cnt_r <= rd_cnt_r + CNT_W'(1);
            if (rd_last_s) begin
               rd_bank_r <= ~rd_bank_r;
            end
         end
      end
   end

   // output FIFO: push the RAM word one cycle after its read was issued
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fifo_data_r[0] <= {DATA_WIDTH{1'b0}};
         fifo_data_r[1] <= {DATA_WIDTH{1'b0}};
         fifo_last_r    <= 2'b00;
         fifo_wr_ptr_r  <= 1'b0;
         fifo_rd_ptr_r  <= 1'b0;
         fifo_cnt_r     <= 2'd0;
      end else begin
         if (inflight_r) begin
            fifo_data_r[fifo_wr_ptr_r] <= bus.ram_q_b;
            fifo_last_r[fifo_wr_ptr_r] <= inflight_last_r;
            fifo_wr_ptr_r              <= ~fifo_wr_ptr_r;
         end
         if (out_fire_s) begin
            fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
         end
         case ({inflight_r, out_fire_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.ram_we_a   = in_fire_s;
   assign bus.ram_addr_a = {wr_bank_r, wr_cnt_r};
   assign bus.ram_data_a = bus.in_data;
   assign bus.ram_addr_b = ram_addr_b_s;
   assign bus.ram_data_b = {DATA_WIDTH{1'b0}};
   assign bus.ram_we_b   = 1'b0;
   assign bus.out_valid  = out_valid_s;
   assign bus.out_data   = fifo_data_r[fifo_rd_ptr_r];
   assign bus.block_done = out_fire_s && fifo_last_r[fifo_rd_ptr_r];

endmodule

// File: tb/tb_dpram_xpose_ctrl.sv
// Self-checking bench for dpram_xpose_ctrl: RAM model, block-level transpose
// reference, per-cycle compare process and directed test sequences.
module tb_dpram_xpose_ctrl;
   localparam int DW = 8;
   localparam int N  = 8;
   localparam int NN = N * N;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   dpram_xpose_ctrl_if #(.DATA_WIDTH(DW), .N(N)) bus ();
`ifdef XPOSE_BYPASS_EN
   logic xpose_bypass = 1'b0;
`endif

   dpram_xpose_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
      .clk          (clk),
      .resetn       (resetn),
`ifdef XPOSE_BYPASS_EN
      .xpose_bypass (xpose_bypass),
`endif
      .bus          (bus)
   );

   // RAM model: true dual port, registered port-B read
   logic [DW-1:0] ram [2*NN];
   always @(posedge clk) begin
      if (bus.ram_we_a) ram[bus.ram_addr_a] <= bus.ram_data_a;
      if (bus.ram_we_b) ram[bus.ram_addr_b] <= bus.ram_data_b;
      bus.ram_q_b <= ram[bus.ram_addr_b];
   end

   // downstream ready: constant or random
   logic ready_const = 1'b1;
   logic rand_mode   = 1'b0;
   logic rand_bit    = 1'b1;
   always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));
   assign bus.out_ready = rand_mode ? rand_bit : ready_const;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   // reference model state
   logic [DW-1:0] part_q[$];
   logic [DW-1:0] full_q[$];
   logic [DW-1:0] out_log[$];
   int            out_cyc[$];
   int  out_idx = 0;
   bit  blk_bypass = 1'b0;
   int  wr_seen = 0;
   int  acc_cnt = 0;
   int  cyc = 0;
   int  last_acc_edge = 0;
   int  first_valid_cyc = -1;
   int  done_cnt = 0;
   int  ready_drop_cnt = 0;
   bit  prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // compare process: checks every DUT output against the block model
   always @(negedge clk) begin
      if (!resetn) begin
         chk(bus.out_valid == 1'b0, "rst_out_valid", int'(bus.out_valid), 0);
         chk(bus.block_done == 1'b0, "rst_block_done", int'(bus.block_done), 0);
         chk(bus.ram_we_a == 1'b0, "rst_ram_we_a", int'(bus.ram_we_a), 0);
         chk(bus.in_ready == 1'b1, "rst_in_ready", int'(bus.in_ready), 1);
         part_q.delete();
         full_q.delete();
         out_idx    = 0;
         wr_seen    = 0;
         prev_stall = 1'b0;
      end else begin
         chk(bus.ram_we_b == 1'b0, "ram_we_b", int'(bus.ram_we_b), 0);
         chk(bus.ram_data_b == '0, "ram_data_b", int'(bus.ram_data_b), 0);
         if (prev_stall) begin
            chk(bus.out_valid == 1'b1, "hold_valid", int'(bus.out_valid), 1);
            chk(bus.out_data == prev_data, "hold_data", int'(bus.out_data), int'(prev_data));
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         if (bus.in_valid && !bus.in_ready) ready_drop_cnt++;
         if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

         // write side: sample k of the stream goes to bank (k/NN)%2, offset k%NN
         if (bus.in_valid && bus.in_ready) begin
            int exp_addr;
            exp_addr = ((wr_seen / NN) % 2) * NN + (wr_seen % NN);
            chk(bus.ram_we_a == 1'b1, "ram_we_a", int'(bus.ram_we_a), 1);
            chk(int'(bus.ram_addr_a) == exp_addr, "ram_addr_a", int'(bus.ram_addr_a), exp_addr);
            chk(bus.ram_data_a == bus.in_data, "ram_data_a", int'(bus.ram_data_a), int'(bus.in_data));
            part_q.push_back(bus.in_data);
            wr_seen++;
            acc_cnt++;
            if (part_q.size() == NN) begin
               foreach (part_q[m]) full_q.push_back(part_q[m]);
               part_q.delete();
               last_acc_edge = cyc + 1;
            end
         end else begin
            chk(bus.ram_we_a == 1'b0, "ram_we_a_idle", int'(bus.ram_we_a), 0);
         end

         // output side: k-th output of a block is element (row k%N, col k/N)
         if (bus.out_valid && bus.out_ready) begin
            if (full_q.size() < NN) begin
               chk(1'b0, "out_unexpected", int'(bus.out_data), -1);
            end else begin
               int k;
               int src;
               if (out_idx == 0) begin
`ifdef XPOSE_BYPASS_EN
                  blk_bypass = xpose_bypass;
`else
                  blk_bypass = 1'b0;
`endif
               end
               k   = out_idx;
               src = blk_bypass ? k : (k % N) * N + k / N;
               chk(bus.out_data == full_q[src], "out_data", int'(bus.out_data), int'(full_q[src]));
               chk(bus.block_done == (k == NN - 1), "block_done", int'(bus.block_done), int'(k == NN - 1));
               out_idx++;
               if (out_idx == NN) begin
                  out_idx = 0;
                  repeat (NN) void'(full_q.pop_front());
               end
            end
            out_log.push_back(bus.out_data);
            out_cyc.push_back(cyc);
            if (bus.block_done) done_cnt++;
         end else begin
            chk(bus.block_done == 1'b0, "done_idle", int'(bus.block_done), 0);
         end
      end
   end

   task automatic send(input logic [DW-1:0] v);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      bus.in_data  = v;
      bus.in_valid = 1'b1;
      while (!ok && n < 600) begin
         @(negedge clk);
         if (bus.in_ready && resetn) ok = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk(1'b0, "send_timeout", n, 600);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic do_reset();
      idle();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      out_log.delete();
      out_cyc.delete();
      done_cnt        = 0;
      ready_drop_cnt  = 0;
      first_valid_cyc = -1;
      acc_cnt         = 0;
   endtask

   task automatic wait_outs(input int n, input int limit);
      int t;
      t = 0;
      while (out_log.size() < n && t < limit) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk(out_log.size() >= n, "wait_outs", out_log.size(), n);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // single block, always-ready sink
      do_reset();
      for (int i = 0; i < NN; i++) send(8'(i));
      idle();
      wait_outs(NN, 200);
      settle(10);
      chk(out_log.size() == NN, "t1_count", out_log.size(), NN);
      if (out_log.size() >= NN) begin
         chk(out_log[0] == 8'd0,  "t1_out0",  int'(out_log[0]), 0);
         chk(out_log[1] == 8'd8,  "t1_out1",  int'(out_log[1]), 8);
         chk(out_log[7] == 8'd56, "t1_out7",  int'(out_log[7]), 56);
         chk(out_log[8] == 8'd1,  "t1_out8",  int'(out_log[8]), 1);
         chk(out_log[9] == 8'd9,  "t1_out9",  int'(out_log[9]), 9);
         chk(out_log[63] == 8'd63, "t1_out63", int'(out_log[63]), 63);
      end
      chk(done_cnt == 1, "t1_done_cnt", done_cnt, 1);
      chk(first_valid_cyc - last_acc_edge == 2, "t1_latency", first_valid_cyc - last_acc_edge, 2);

      // two back-to-back blocks at full rate
      do_reset();
      for (int i = 0; i < 2 * NN; i++) send(8'(i));
      idle();
      wait_outs(2 * NN, 300);
      settle(10);
      chk(out_log.size() == 2 * NN, "t2_count", out_log.size(), 2 * NN);
      chk(ready_drop_cnt == 0, "t2_in_ready_drop", ready_drop_cnt, 0);
      chk(done_cnt == 2, "t2_done_cnt", done_cnt, 2);
      if (out_log.size() >= 2 * NN) begin
         chk(out_log[64] == 8'd64, "t2_out64", int'(out_log[64]), 64);
         chk(out_log[65] == 8'd72, "t2_out65", int'(out_log[65]), 72);
         chk(out_cyc[127] - out_cyc[0] == 127, "t2_no_gaps", out_cyc[127] - out_cyc[0], 127);
      end

      // blocked sink: writer fills both banks and stops at 128
      do_reset();
      ready_const = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) send(8'(i));
            idle();
         end
         begin
            int t;
            t = 0;
            while (acc_cnt < 2 * NN && t < 1000) begin
               @(posedge clk);
               t++;
            end
            settle(20);
            chk(acc_cnt == 2 * NN, "t3_accepted_stall", acc_cnt, 2 * NN);
            chk(bus.in_ready == 1'b0, "t3_in_ready_low", int'(bus.in_ready), 0);
            chk(out_log.size() == 0, "t3_no_out_stalled", out_log.size(), 0);
            ready_const = 1'b1;
         end
      join
      wait_outs(3 * NN, 600);
      settle(10);
      chk(acc_cnt == 200, "t3_accepted_total", acc_cnt, 200);
      chk(done_cnt == 3, "t3_done_cnt", done_cnt, 3);
      if (out_log.size() >= 3 * NN) begin
         chk(out_log[127] == 8'd127, "t3_out127", int'(out_log[127]), 127);
         chk(out_log[128] == 8'd128, "t3_out128", int'(out_log[128]), 128);
         chk(out_log[129] == 8'd136, "t3_out129", int'(out_log[129]), 136);
      end

      // random backpressure over four blocks
      do_reset();
      rand_mode = 1'b1;
      for (int i = 0; i < 4 * NN; i++) send(8'(i));
      idle();
      wait_outs(4 * NN, 2000);
      rand_mode = 1'b0;
      settle(10);
      chk(out_log.size() == 4 * NN, "t4_count", out_log.size(), 4 * NN);
      chk(done_cnt == 4, "t4_done_cnt", done_cnt, 4);

      // reset in the middle of a block discards it
      do_reset();
      for (int i = 0; i < 30; i++) send(8'(i + 100));
      idle();
      settle(3);
      do_reset();
      for (int i = 0; i < NN; i++) send(8'(i));
      idle();
      wait_outs(NN, 200);
      settle(10);
      chk(out_log.size() == NN, "t5_count", out_log.size(), NN);
      if (out_log.size() >= NN) begin
         chk(out_log[0] == 8'd0,   "t5_out0",  int'(out_log[0]), 0);
         chk(out_log[1] == 8'd8,   "t5_out1",  int'(out_log[1]), 8);
         chk(out_log[63] == 8'd63, "t5_out63", int'(out_log[63]), 63);
      end

`ifdef XPOSE_BYPASS_EN
      // bypass on block 0, transposed block 1, toggles mid-block ignored
      do_reset();
      xpose_bypass = 1'b1;
      for (int i = 0; i < NN; i++) send(8'(i));
      idle();
      settle(4);
      for (int i = 0; i < NN; i++) begin
         xpose_bypass = (i < 50) ? 1'(i % 2) : 1'b0;
         send(8'(NN + i));
      end
      idle();
      wait_outs(NN + 10, 300);
      xpose_bypass = 1'b1;
      settle(3);
      xpose_bypass = 1'b0;
      wait_outs(2 * NN, 300);
      settle(10);
      chk(done_cnt == 2, "t6_done_cnt", done_cnt, 2);
      if (out_log.size() >= 2 * NN) begin
         chk(out_log[1] == 8'd1,   "t6_out1",  int'(out_log[1]), 1);
         chk(out_log[8] == 8'd8,   "t6_out8",  int'(out_log[8]), 8);
         chk(out_log[63] == 8'd63, "t6_out63", int'(out_log[63]), 63);
         chk(out_log[64] == 8'd64, "t6_out64", int'(out_log[64]), 64);
         chk(out_log[65] == 8'd72, "t6_out65", int'(out_log[65]), 72);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
